// File: rtl/bit_printer_pkg.sv
// Shared constants, state encoding and small helpers for the bit-string printer.
package bit_printer_pkg;

   localparam logic [7:0] CHAR_0   = 8'h30;
   localparam logic [7:0] CHAR_1   = 8'h31;
   localparam logic [7:0] CHAR_BS  = 8'h08;
   localparam logic [7:0] CHAR_DEL = 8'h7F;
   localparam logic [7:0] CHAR_ESC = 8'h1B;
   localparam logic [7:0] CHAR_CR  = 8'h0D;
   localparam logic [7:0] CHAR_LF  = 8'h0A;

   typedef enum logic [0:0] {
      StCollect = 1'b0,
      StPrint   = 1'b1
   } state_e;

   function automatic logic [7:0] digit_char(input logic b);
      return b ? CHAR_1 : CHAR_0;
   endfunction

   function automatic logic is_digit(input logic [7:0] c);
      return (c == CHAR_0) || (c == CHAR_1);
   endfunction

   function automatic logic is_erase(input logic [7:0] c);
      return (c == CHAR_BS) || (c == CHAR_DEL);
   endfunction

endpackage

// File: rtl/uart_tx_sequencer.sv
// Issues bytes to the UART transmitter: honours tx_busy and leaves a one-cycle gap after each
// strobe so the transmitter has time to raise busy.
module uart_tx_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_i,
   input  logic       valid_i,
   output logic       ready_o,
   input  logic       tx_busy_i,
   output logic [7:0] tx_data_o,
   output logic       new_tx_data_o
);

   logic [7:0] tx_data_q, tx_data_d;
   logic       new_tx_data_q, new_tx_data_d;

   assign ready_o       = !tx_busy_i && !new_tx_data_q;
   assign tx_data_o     = tx_data_q;
   assign new_tx_data_o = new_tx_data_q;

   // Next-state: load and strobe only on an accepted byte; otherwise hold the data.
   always_comb begin
      tx_data_d     = tx_data_q;
      new_tx_data_d = 1'b0;
      if (valid_i && ready_o) begin
         tx_data_d     = data_i;
         new_tx_data_d = 1'b1;
      end
   end

   // Output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_data_q     <= 8'h00;
         new_tx_data_q <= 1'b0;
      end else begin
         tx_data_q     <= tx_data_d;
         new_tx_data_q <= new_tx_data_d;
      end
   end

endmodule

// File: rtl/bit_string_printer.sv
// Collects NUM_BITS ASCII binary digits with backspace/escape editing and optional echo,
// then prints them (reversed or forward, optional CR LF) and presents them as a parallel word.
module bit_string_printer
   import bit_printer_pkg::*;
#(
   parameter int unsigned NUM_BITS     = 8,
   parameter bit          REVERSE      = 1'b1,
   parameter bit          SEND_NEWLINE = 1'b1,
   parameter bit          ECHO         = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          rx_data_i,
   input  logic                new_rx_data_i,
   output logic [7:0]          tx_data_o,
   output logic                new_tx_data_o,
   input  logic                tx_busy_i,
   output logic [NUM_BITS-1:0] bits_out_o,
   output logic                bits_valid_o,
   output logic                collecting_o
);

   localparam int unsigned CW       = $clog2(NUM_BITS + 1);
   localparam int unsigned NumBytes = NUM_BITS + (SEND_NEWLINE ? 2 : 0);
   localparam int unsigned IW       = $clog2(NumBytes + 1);

   localparam logic [CW-1:0] CountLast = CW'(NUM_BITS - 1);
   localparam logic [IW-1:0] IdxLast   = IW'(NumBytes - 1);
   localparam logic [IW-1:0] IdxCr     = IW'(NUM_BITS);

   state_e              state_q, state_d;
   logic [CW-1:0]       count_q, count_d;
   logic [NUM_BITS-1:0] digit_q, digit_d;
   logic                echo_pend_q, echo_pend_d;
   logic                echo_bit_q, echo_bit_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [NUM_BITS-1:0] bits_out_q, bits_out_d;
   logic                bits_valid_q, bits_valid_d;

   logic       rx_digit, rx_erase, rx_esc;
   logic [7:0] seq_data;
   logic       seq_valid, seq_ready, handshake, echo_sent, echo_free;
   logic       print_bit;

   assign rx_digit  = new_rx_data_i && is_digit(rx_data_i);
   assign rx_erase  = new_rx_data_i && is_erase(rx_data_i);
   assign rx_esc    = new_rx_data_i && (rx_data_i == CHAR_ESC);
   assign handshake = seq_valid && seq_ready;
   assign echo_sent = handshake && echo_pend_q;
   // A slot being drained this cycle may take the next echo.
   assign echo_free = !echo_pend_q || echo_sent;

   assign bits_out_o   = bits_out_q;
   assign bits_valid_o = bits_valid_q;
   assign collecting_o = (state_q == StCollect);

   // Transmit source: a pending echo always wins, then the print sequence.
   always_comb begin
      seq_valid = 1'b0;
      seq_data  = CHAR_0;
      print_bit = 1'b0;
      for (int i = 0; i < NUM_BITS; i++) begin
         if (idx_q == IW'(i)) begin
            print_bit = REVERSE ? digit_q[NUM_BITS-1-i] : digit_q[i];
         end
      end
      if (echo_pend_q) begin
         seq_valid = 1'b1;
         seq_data  = digit_char(echo_bit_q);
      end else if (state_q == StPrint) begin
         seq_valid = 1'b1;
         if (idx_q < IW'(NUM_BITS)) begin
            seq_data = digit_char(print_bit);
         end else if (idx_q == IdxCr) begin
            seq_data = CHAR_CR;
         end else begin
            seq_data = CHAR_LF;
         end
      end
   end

   // Collect/print FSM next-state, digit buffer, echo slot and print index.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      digit_d      = digit_q;
      echo_pend_d  = echo_pend_q;
      echo_bit_d   = echo_bit_q;
      idx_d        = idx_q;
      bits_out_d   = bits_out_q;
      bits_valid_d = 1'b0;

      if (echo_sent) begin
         echo_pend_d = 1'b0;
      end

      case (state_q)
         StCollect: begin
            if (rx_digit) begin
               for (int i = 0; i < NUM_BITS; i++) begin
                  if (count_q == CW'(i)) begin
                     digit_d[i] = rx_data_i[0];
                  end
               end
               count_d = count_q + 1'b1;
               // Slot busy: the digit is kept, only its echo is lost.
               if (ECHO && echo_free) begin
                  echo_pend_d = 1'b1;
                  echo_bit_d  = rx_data_i[0];
               end
               if (count_q == CountLast) begin
                  // First-typed digit lands in the MSB.
                  for (int i = 0; i < NUM_BITS; i++) begin
                     bits_out_d[NUM_BITS-1-i] = digit_d[i];
                  end
                  bits_valid_d = 1'b1;
                  state_d      = StPrint;
                  idx_d        = '0;
               end
            end else if (rx_erase) begin
               if (count_q != '0) begin
                  count_d = count_q - 1'b1;
               end
            end else if (rx_esc) begin
               count_d = '0;
            end
         end
         StPrint: begin
            if (handshake && !echo_pend_q) begin
               if (idx_q == IdxLast) begin
                  state_d = StCollect;
                  count_d = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = StCollect;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StCollect;
         count_q      <= '0;
         digit_q      <= '0;
         echo_pend_q  <= 1'b0;
         echo_bit_q   <= 1'b0;
         idx_q        <= '0;
         bits_out_q   <= '0;
         bits_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         digit_q      <= digit_d;
         echo_pend_q  <= echo_pend_d;
         echo_bit_q   <= echo_bit_d;
         idx_q        <= idx_d;
         bits_out_q   <= bits_out_d;
         bits_valid_q <= bits_valid_d;
      end
   end

   uart_tx_sequencer u_tx_seq (
      .clk           (clk),
      .rst           (rst),
      .data_i        (seq_data),
      .valid_i       (seq_valid),
      .ready_o       (seq_ready),
      .tx_busy_i     (tx_busy_i),
      .tx_data_o     (tx_data_o),
      .new_tx_data_o (new_tx_data_o)
   );

endmodule

// File: tb/tb_bit_string_printer.sv
// Directed bench for bit_string_printer: a 3-digit reversed instance and an 8-digit forward one.
module tb_bit_string_printer;

   logic       clk;
   logic       rst3, rst8;
   logic [7:0] rx3, rx8;
   logic       nrx3, nrx8;
   logic [7:0] tx3, tx8;
   logic       ntx3, ntx8;
   logic       busy3, busy8;
   logic [2:0] bits3;
   logic [7:0] bits8;
   logic       bv3, bv8;
   logic       col3, col8;

   int passes = 0;
   int total  = 0;

   logic [7:0] q3[$];
   logic [7:0] q8[$];
   int viol3 = 0, viol8 = 0;
   int bvc3 = 0, bvc8 = 0;
   logic sp3 = 1'b0, bp3 = 1'b0, sp8 = 1'b0, bp8 = 1'b0;

   bit_string_printer #(
      .NUM_BITS(3), .REVERSE(1'b1), .SEND_NEWLINE(1'b1), .ECHO(1'b1)
   ) dut3 (
      .clk           (clk),
      .rst           (rst3),
      .rx_data_i     (rx3),
      .new_rx_data_i (nrx3),
      .tx_data_o     (tx3),
      .new_tx_data_o (ntx3),
      .tx_busy_i     (busy3),
      .bits_out_o    (bits3),
      .bits_valid_o  (bv3),
      .collecting_o  (col3)
   );

   bit_string_printer #(
      .NUM_BITS(8), .REVERSE(1'b0), .SEND_NEWLINE(1'b1), .ECHO(1'b1)
   ) dut8 (
      .clk           (clk),
      .rst           (rst8),
      .rx_data_i     (rx8),
      .new_rx_data_i (nrx8),
      .tx_data_o     (tx8),
      .new_tx_data_o (ntx8),
      .tx_busy_i     (busy8),
      .bits_out_o    (bits8),
      .bits_valid_o  (bv8),
      .collecting_o  (col8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Log transmitted bytes; flag strobes issued while busy was seen or right after a strobe.
   always @(negedge clk) begin
      if (ntx3) begin
         q3.push_back(tx3);
         if (bp3 || sp3) viol3++;
      end
      if (ntx8) begin
         q8.push_back(tx8);
         if (bp8 || sp8) viol8++;
      end
      sp3 = ntx3; bp3 = busy3;
      sp8 = ntx8; bp8 = busy8;
      if (bv3) bvc3++;
      if (bv8) bvc8++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send3(input logic [7:0] c);
      rx3 = c; nrx3 = 1'b1;
      tick(1);
      nrx3 = 1'b0;
      tick(3);
   endtask

   task automatic send8(input logic [7:0] c);
      rx8 = c; nrx8 = 1'b1;
      tick(1);
      nrx8 = 1'b0;
      tick(3);
   endtask

   task automatic wait_col(input string tag, input int which);
      int n = 0;
      while (((which == 3) ? col3 : col8) !== 1'b1 && n < 400) begin
         tick(1);
         n++;
      end
      chk(tag, (which == 3) ? col3 : col8, 1'b1);
      tick(4);
   endtask

   task automatic wait_bytes3(input string tag, input int target);
      int n = 0;
      while (q3.size() < target && n < 300) begin
         tick(1);
         n++;
      end
      chk(tag, (q3.size() >= target) ? 1 : 0, 1);
   endtask

   task automatic chk_stream(input string tag, input int which, input int base, input string exp);
      int sz;
      logic [7:0] got;
      sz = (which == 3) ? q3.size() : q8.size();
      chk({tag, "_len"}, sz - base, exp.len());
      for (int i = 0; i < exp.len(); i++) begin
         got = 8'hFF;
         if (base + i < sz) got = (which == 3) ? q3[base+i] : q8[base+i];
         chk(tag, got, {24'h0, exp[i]});
      end
   endtask

   initial begin
      int base, bvb;
      rst3 = 1'b1; rst8 = 1'b1;
      rx3 = 8'h00; rx8 = 8'h00; nrx3 = 1'b0; nrx8 = 1'b0;
      busy3 = 1'b0; busy8 = 1'b0;
      tick(3);
      rst3 = 1'b0; rst8 = 1'b0;
      tick(1);

      // Reset state
      chk("rst_tx_data", tx3, 8'h00);
      chk("rst_new_tx", ntx3, 1'b0);
      chk("rst_bits_out", bits3, 3'b000);
      chk("rst_bits_valid", bv3, 1'b0);
      chk("rst_collecting", col3, 1'b1);
      chk("rst_collecting8", col8, 1'b1);

      // "001" reversed with echo
      base = q3.size(); bvb = bvc3;
      send3("0"); send3("0"); send3("1");
      chk("t1_in_print", col3, 1'b0);
      wait_col("t1_done", 3);
      chk_stream("t1_stream", 3, base, "001100\r\n");
      chk("t1_bits_out", bits3, 3'b001);
      chk("t1_bv_pulses", bvc3 - bvb, 1);

      // Ignored byte and backspace
      base = q3.size(); bvb = bvc3;
      send3("1"); send3("x"); send3("0"); send3(8'h08); send3("1"); send3("1");
      wait_col("t2_done", 3);
      chk_stream("t2_stream", 3, base, "1011111\r\n");
      chk("t2_bits_out", bits3, 3'b111);
      chk("t2_bv_pulses", bvc3 - bvb, 1);

      // Escape discards the partial string; DEL at count 0 is ignored
      base = q3.size();
      send3(8'h7F); send3("0"); send3("1"); send3(8'h1B); send3("0"); send3("1"); send3("0");
      wait_col("t3_done", 3);
      chk_stream("t3_stream", 3, base, "01010010\r\n");
      chk("t3_bits_out", bits3, 3'b010);

      // Echo slot full: second digit stored but its echo dropped
      base = q3.size();
      busy3 = 1'b1;
      send3("1"); send3("0");
      busy3 = 1'b0;
      tick(4);
      send3("1");
      wait_col("t4_done", 3);
      chk_stream("t4_stream", 3, base, "11101\r\n");
      chk("t4_bits_out", bits3, 3'b101);

      // tx_busy held 50 cycles after the 2nd printed byte
      base = q3.size();
      send3("1"); send3("0"); send3("1");
      wait_bytes3("t5_reach", base + 5);
      busy3 = 1'b1;
      tick(50);
      chk("t5_no_tx_busy", q3.size() - base, 5);
      busy3 = 1'b0;
      wait_col("t5_done", 3);
      chk_stream("t5_stream", 3, base, "101101\r\n");
      chk("t5_handshake_viol", viol3, 0);

      // Reset after the 2nd printed byte aborts printing
      base = q3.size();
      send3("1"); send3("0"); send3("0");
      wait_bytes3("t6_reach", base + 5);
      rst3 = 1'b1;
      base = q3.size();
      tick(1);
      rst3 = 1'b0;
      chk("t6_new_tx", ntx3, 1'b0);
      chk("t6_collecting", col3, 1'b1);
      chk("t6_bits_out", bits3, 3'b000);
      chk("t6_tx_data", tx3, 8'h00);
      tick(40);
      chk("t6_no_more_tx", q3.size() - base, 0);
      // count restarted at zero: exactly three more digits complete a string
      base = q3.size();
      send3("1"); send3("1");
      chk("t6_still_collect", col3, 1'b1);
      send3("0");
      wait_col("t6_done", 3);
      chk_stream("t6_stream", 3, base, "110011\r\n");
      chk("t6_bits_out2", bits3, 3'b110);
      chk("t6_handshake_viol", viol3, 0);

      // 8 digits, forward order
      base = q8.size(); bvb = bvc8;
      send8("1"); send8("0"); send8("1"); send8("1");
      send8("0"); send8("0"); send8("1"); send8("0");
      wait_col("t7_done", 8);
      chk_stream("t7_stream", 8, base, "1011001010110010\r\n");
      chk("t7_bits_out", bits8, 8'hB2);
      chk("t7_bv_pulses", bvc8 - bvb, 1);
      chk("t7_handshake_viol", viol8, 0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
